// File: rtl/axilite_bk_regfile_if.sv
// Backend request/response bus between the AXI-Lite slave front end and its register target.
interface axilite_bk_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  bk_valid;
    logic                  bk_rd_wr;
    logic [ADDR_WIDTH-1:0] bk_addr;
    logic [31:0]           bk_wdata;
    logic [3:0]            bk_wstrb;
    logic                  bk_ready;
    logic [31:0]           bk_rdata;

    modport master (
        output bk_valid, bk_rd_wr, bk_addr, bk_wdata, bk_wstrb,
        input  bk_ready, bk_rdata
    );

    modport slave (
        input  bk_valid, bk_rd_wr, bk_addr, bk_wdata, bk_wstrb,
        output bk_ready, bk_rdata
    );
endinterface

// File: rtl/axilite_bk_regfile.sv
// Register-file backend: NUM_REGS byte-strobed 32-bit config registers behind the backend
// request bus, with a fixed response latency and a sticky out-of-range flag.
module axilite_bk_regfile #(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] OOR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    axilite_bk_regfile_if.slave       bk,
    output logic [NUM_REGS*32-1:0]    user_regs,
    output logic                      oor_err,
    input  logic                      oor_clr
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic             rd_wr;
        logic             in_range;
        logic [SEL_W-1:0] sel;
        logic [31:0]      wdata;
        logic [3:0]       wstrb;
    } req_t;

    state_t                         state_q;
    req_t                           req_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [NUM_REGS-1:0][31:0]      regs_q;

    logic [IDX_W-1:0] idx_c;
    logic             in_range_c;
    logic [SEL_W-1:0] sel_c;
    logic             unused_addr_c;

    // Word decode of the live request; the two byte-offset bits carry no meaning here.
    assign idx_c         = bk.bk_addr[ADDR_WIDTH-1:2];
    assign in_range_c    = 32'(idx_c) < NUM_REGS;
    assign sel_c         = SEL_W'(idx_c);
    assign unused_addr_c = ^bk.bk_addr[1:0];

    assign user_regs = regs_q;

    function automatic logic [31:0] ack_rdata(input logic rd_wr, input logic in_range,
                                              input logic [SEL_W-1:0] sel);
        if (!rd_wr)        return 32'h0;
        else if (in_range) return regs_q[sel];
        else               return OOR_RDATA;
    endfunction

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            regs_q      <= '0;
            oor_err     <= 1'b0;
            bk.bk_ready <= 1'b0;
            bk.bk_rdata <= 32'h0;
        end else begin
            // Clear first so an out-of-range completion in the same cycle overrides it.
            if (oor_clr) begin
                oor_err <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bk.bk_valid) begin
                        req_q.rd_wr    <= bk.bk_rd_wr;
                        req_q.in_range <= in_range_c;
                        req_q.sel      <= sel_c;
                        req_q.wdata    <= bk.bk_wdata;
                        req_q.wstrb    <= bk.bk_wstrb;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= S_ACK;
                            bk.bk_ready <= 1'b1;
                            bk.bk_rdata <= ack_rdata(bk.bk_rd_wr, in_range_c, sel_c);
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_ACK;
                        bk.bk_ready <= 1'b1;
                        bk.bk_rdata <= ack_rdata(req_q.rd_wr, req_q.in_range, req_q.sel);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                S_ACK: begin
                    state_q     <= S_DONE;
                    bk.bk_ready <= 1'b0;
                    bk.bk_rdata <= 32'h0;
                    if (!req_q.in_range) begin
                        oor_err <= 1'b1;
                    end else if (!req_q.rd_wr) begin
                        for (int k = 0; k < 4; k++) begin
                            if (req_q.wstrb[k]) begin
                                regs_q[req_q.sel][8*k +: 8] <= req_q.wdata[8*k +: 8];
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
